// File: rtl/uart_tx.sv
// UART transmitter: start bit, BIT_WIDTH data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
    parameter int CLOCK_BAUD_RATIO = 400,
    parameter int BIT_WIDTH        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = (CLOCK_BAUD_RATIO > 2) ? $clog2(CLOCK_BAUD_RATIO) : 1;
    localparam int IW = $clog2(BIT_WIDTH + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLOCK_BAUD_RATIO - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BIT_WIDTH - 1);

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CNT_MAX);
    assign ready   = (state_q == S_IDLE) && !rst;
    assign busy    = (state_q != S_IDLE);
    assign tx      = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = data_in;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Reset aborts any frame in flight; the line returns to idle immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line expectations queued at acceptance, popped each cycle.
module tb_uart_tx;

    localparam int R = 4;
    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (W + 2 + P) * R;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         valid;
    logic         ready;
    logic         tx;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];

    uart_tx #(.CLOCK_BAUD_RATIO(R), .BIT_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .valid(valid),
        .ready(ready),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        for (int i = 0; i < R; i++) exp_q.push_back(b);
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        push_bit(1'b0);
        for (int i = 0; i < W; i++) push_bit(d[i]);
        if (P != 0) push_bit(^d);
        push_bit(1'b1);
    endtask

    // Offer d at the next edge; inputs change on negedge, away from posedge.
    task automatic accept(input logic [W-1:0] d, input bit hold);
        data_in = d;
        valid   = 1'b1;
        chk("ready_before_accept", {31'b0, ready}, 32'd1);
        push_frame(d);
        @(posedge clk);
        @(negedge clk);
        if (!hold) valid = 1'b0;
    endtask

    // Check n line cycles; optionally poke data/valid at cycle glitch.
    task automatic run_cycles(input int n, input int glitch);
        logic e;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (i == glitch) begin
                data_in = 8'h5A;
                valid   = 1'b1;
            end else if (i == glitch + 1) begin
                valid = 1'b0;
            end
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            chk("tx_bit", {31'b0, tx}, {31'b0, e});
            chk("busy_in_frame", {31'b0, busy}, 32'd1);
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("ready_after", {31'b0, ready}, 32'd1);
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("tx_gap", {31'b0, tx}, 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_rst", {31'b0, ready}, 32'd1);
        chk("tx_post_rst", {31'b0, tx}, 32'd1);

        // Single word
        accept(8'hA5, 1'b0);
        run_cycles(FRAME, -10);
        chk("queue_empty_a5", exp_q.size(), 32'd0);
        check_idle();

        // Back-to-back with valid held: one gap cycle between frames
        accept(8'h00, 1'b1);
        run_cycles(FRAME, -10);
        @(negedge clk);
        chk("b2b_gap_tx", {31'b0, tx}, 32'd1);
        chk("b2b_gap_ready", {31'b0, ready}, 32'd1);
        chk("b2b_gap_busy", {31'b0, busy}, 32'd0);
        accept(8'hFF, 1'b0);
        run_cycles(FRAME, -10);
        check_idle();

        // Mid-frame reset during data bit 2
        accept(8'h0F, 1'b0);
        run_cycles(4 * R - 1, -10);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_tx", {31'b0, tx}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        accept(8'h3C, 1'b0);
        run_cycles(FRAME, -10);
        check_idle();

        // Parity-sensitive word (odd popcount)
        accept(8'h07, 1'b0);
        run_cycles(FRAME, -10);
        check_idle();

        // Inputs ignored while busy
        accept(8'hC3, 1'b0);
        run_cycles(FRAME, 13);
        check_idle();
        repeat (2 * R) begin
            @(negedge clk);
            chk("no_extra_frame_tx", {31'b0, tx}, 32'd1);
            chk("no_extra_frame_busy", {31'b0, busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
